// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared constants for the hazard scoreboard: flag bit
//                positions, branch condition codes and the mapping from a
//                condition code to the flags it reads.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Bit positions of the flags inside every 3-bit flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Branch condition codes
    localparam logic [2:0] COND_EQ = 3'b000;  // Z
    localparam logic [2:0] COND_NE = 3'b001;  // Z
    localparam logic [2:0] COND_LE = 3'b010;  // Z,N
    localparam logic [2:0] COND_LT = 3'b011;  // N
    localparam logic [2:0] COND_GT = 3'b100;  // Z,N
    localparam logic [2:0] COND_GE = 3'b101;  // Z,N
    localparam logic [2:0] COND_VS = 3'b110;  // V
    localparam logic [2:0] COND_AL = 3'b111;  // unconditional, reads nothing

    // Flags a branch with condition code 'cond' must see committed
    function automatic logic [2:0] cond_flag_mask(input logic [2:0] cond);
        logic [2:0] m;
        m = '0;
        case (cond)
            COND_EQ, COND_NE:          m[FLAG_Z] = 1'b1;
            COND_LE, COND_GT, COND_GE: begin
                m[FLAG_Z] = 1'b1;
                m[FLAG_N] = 1'b1;
            end
            COND_LT:                   m[FLAG_N] = 1'b1;
            COND_VS:                   m[FLAG_V] = 1'b1;
            default:                   m = '0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sb_cnt
//  Description : One scoreboard slot. Loadable down-counter that stops at 0;
//                busy flags an in-flight producer. A load wins over the
//                decrement so the newest writer owns the slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb_cnt
    import hazard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    // Reload on issue, otherwise drain toward zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Countdown-scoreboard hazard unit beside the ID stage.
//                Detects load-to-use, register-branch-source and
//                flag-to-branch hazards and drives PC / IF-ID enables, the
//                ID/EX bubble and the IF/ID flush.
//                Optional: HAZ_PERF_CNT_EN adds stall/flush perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG         = 16,
    parameter int RIDX_W       = 4,
    parameter int WB_DIST      = 3,
    parameter int FLAG_DIST    = 1,
    parameter int BR_RF_THRESH = 1,
    parameter int CNT_W        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RIDX_W-1:0] id_rs,
    input  logic [RIDX_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [2:0]        id_flag_en,
    input  logic              id_branch,
    input  logic              id_branchr,
    input  logic [2:0]        id_br_cond,
    input  logic              id_br_taken,
    output logic              pc_wen,
    output logic              if_id_wen,
    output logic              id_ex_bubble,
    output logic              if_id_flush
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    localparam logic [CNT_W-1:0] C_WB_VAL    = CNT_W'(WB_DIST);
    localparam logic [CNT_W-1:0] C_FLAG_VAL  = CNT_W'(FLAG_DIST);
    localparam logic [CNT_W-1:0] C_BR_THRESH = CNT_W'(BR_RF_THRESH);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    logic [CNT_W-1:0] reg_cnt  [NREG];
    logic             reg_busy [NREG];
    logic             reg_ld   [NREG];
    logic [CNT_W-1:0] flag_cnt [3];
    logic [2:0]       flag_pending;

    logic w_stall;
    logic w_issue;
    logic w_l2u;
    logic w_brr;
    logic w_flg;

    // r0 is hard-wired and never produces a hazard
    assign reg_cnt[0]  = '0;
    assign reg_busy[0] = 1'b0;
    assign reg_ld[0]   = 1'b0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_reg
            logic w_load;
            assign w_load = w_issue & id_reg_write & (id_rd == RIDX_W'(i));

            hazard_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (w_load),
                .load_val (C_WB_VAL),
                .cnt      (reg_cnt[i]),
                .busy     (reg_busy[i])
            );

            // Remember whether the newest writer is a load; forget it as the slot empties
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    reg_ld[i] <= 1'b0;
                end else if (w_load) begin
                    reg_ld[i] <= id_mem_read;
                end else if (!reg_busy[i] || reg_cnt[i] == C_ONE) begin
                    reg_ld[i] <= 1'b0;
                end
            end
        end

        for (genvar f = 0; f < 3; f++) begin : g_flag
            hazard_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (w_issue & id_flag_en[f]),
                .load_val (C_FLAG_VAL),
                .cnt      (flag_cnt[f]),
                .busy     (flag_pending[f])
            );
        end
    endgenerate

    // Hazard detection for the instruction currently in ID
    always_comb begin
        w_l2u = 1'b0;
        w_brr = 1'b0;
        w_flg = 1'b0;
        // Load result is not yet available to EX one cycle after the load issued
        if (id_rs_used && id_rs != '0 && reg_ld[id_rs] && reg_cnt[id_rs] == C_WB_VAL)
            w_l2u = 1'b1;
        // Store data bypasses MEM-to-MEM, so only a true rt read can hazard
        if (id_rt_used && !id_mem_write && id_rt != '0 &&
            reg_ld[id_rt] && reg_cnt[id_rt] == C_WB_VAL)
            w_l2u = 1'b1;
        // Register branch reads its target from the RF in ID
        if (id_branchr && id_rs != '0 && reg_cnt[id_rs] > C_BR_THRESH)
            w_brr = 1'b1;
        // Branch condition evaluated in ID needs its flags committed
        if ((id_branch || id_branchr) && |(cond_flag_mask(id_br_cond) & flag_pending))
            w_flg = 1'b1;
    end

    assign w_stall      = id_valid & (w_l2u | w_brr | w_flg);
    assign w_issue      = id_valid & ~w_stall;

    assign pc_wen       = ~w_stall;
    assign if_id_wen    = ~w_stall;
    assign id_ex_bubble = w_stall;
    assign if_id_flush  = id_valid & (id_branch | id_branchr) & id_br_taken & ~w_stall;

`ifdef HAZ_PERF_CNT_EN
    // Saturating counters of stall cycles and taken-branch flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (w_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush && flush_count != '1)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. A table of
//                per-cycle ID contents with expected stall/flush, plus a
//                hand-written asynchronous reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used;
    logic       id_reg_write, id_mem_read, id_mem_write;
    logic [2:0] id_flag_en;
    logic       id_branch, id_branchr;
    logic [2:0] id_br_cond;
    logic       id_br_taken;
    logic       pc_wen, if_id_wen, id_ex_bubble, if_id_flush;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_flag_en   (id_flag_en),
        .id_branch    (id_branch),
        .id_branchr   (id_branchr),
        .id_br_cond   (id_br_cond),
        .id_br_taken  (id_br_taken),
        .pc_wen       (pc_wen),
        .if_id_wen    (if_id_wen),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    typedef struct packed {
        logic       do_rst;
        logic       valid;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic [3:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] flag_en;
        logic       branch;
        logic       branchr;
        logic [2:0] cond;
        logic       taken;
        logic       exp_stall;
        logic       exp_flush;
    } vec_t;

    vec_t       tbl [64];
    int         n_vec    = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q [$];

    function automatic vec_t f_nop();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t f_alu(input int rd, input int rs, input int rt, input logic [2:0] fl);
        vec_t v;
        v = '0;
        v.valid = 1'b1; v.rd = 4'(rd); v.rs = 4'(rs); v.rt = 4'(rt);
        v.rs_used = 1'b1; v.rt_used = 1'b1; v.reg_write = 1'b1; v.flag_en = fl;
        return v;
    endfunction

    function automatic vec_t f_ldr(input int rd, input int rs);
        vec_t v;
        v = '0;
        v.valid = 1'b1; v.rd = 4'(rd); v.rs = 4'(rs);
        v.rs_used = 1'b1; v.reg_write = 1'b1; v.mem_read = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_sw(input int rs, input int rt);
        vec_t v;
        v = '0;
        v.valid = 1'b1; v.rs = 4'(rs); v.rt = 4'(rt);
        v.rs_used = 1'b1; v.rt_used = 1'b1; v.mem_write = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_br(input int cond, input logic taken);
        vec_t v;
        v = '0;
        v.valid = 1'b1; v.branch = 1'b1; v.cond = 3'(cond); v.taken = taken;
        return v;
    endfunction

    function automatic vec_t f_brr(input int rs, input int cond, input logic taken);
        vec_t v;
        v = '0;
        v.valid = 1'b1; v.branchr = 1'b1; v.rs = 4'(rs); v.rs_used = 1'b1;
        v.cond = 3'(cond); v.taken = taken;
        return v;
    endfunction

    task automatic add(input vec_t v, input logic st, input logic fl, input logic r);
        v.exp_stall = st;
        v.exp_flush = fl;
        v.do_rst    = r;
        tbl[n_vec]  = v;
        n_vec++;
    endtask

    task automatic drive(input vec_t v);
        id_valid     = v.valid;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_rs_used   = v.rs_used;
        id_rt_used   = v.rt_used;
        id_rd        = v.rd;
        id_reg_write = v.reg_write;
        id_mem_read  = v.mem_read;
        id_mem_write = v.mem_write;
        id_flag_en   = v.flag_en;
        id_branch    = v.branch;
        id_branchr   = v.branchr;
        id_br_cond   = v.cond;
        id_br_taken  = v.taken;
    endtask

    task automatic push_exp(input logic st, input logic fl);
        exp_q.push_back({~st, ~st, st, fl});
    endtask

    task automatic check(input int idx);
        logic [3:0] e;
        logic [3:0] a;
        a = {pc_wen, if_id_wen, id_ex_bubble, if_id_flush};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL step %0d: scoreboard queue empty, got %b", idx, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL step %0d: {pc_wen,if_id_wen,bubble,flush} got %b expected %b",
                         idx, a, e);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v);
        push_exp(v.exp_stall, v.exp_flush);
        @(negedge clk);
        check(idx);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int idx);
        drive(f_nop());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(1'b0, 1'b0);
        @(negedge clk);
        check(idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(f_nop());

        // Load-to-use: exactly one stall cycle
        add(f_ldr(3, 1),                 1'b0, 1'b0, 1'b1);
        add(f_alu(5, 3, 1, 3'b000),      1'b1, 1'b0, 1'b0);
        add(f_alu(5, 3, 1, 3'b000),      1'b0, 1'b0, 1'b0);
        add(f_nop(),                     1'b0, 1'b0, 1'b0);
        // Store data is forwarded; store base is not
        add(f_ldr(3, 1),                 1'b0, 1'b0, 1'b0);
        add(f_sw(1, 3),                  1'b0, 1'b0, 1'b0);
        add(f_ldr(3, 1),                 1'b0, 1'b0, 1'b0);
        add(f_sw(3, 1),                  1'b1, 1'b0, 1'b0);
        add(f_sw(3, 1),                  1'b0, 1'b0, 1'b0);
        // Register branch waits until the producer is in WB
        add(f_alu(4, 1, 2, 3'b000),      1'b0, 1'b0, 1'b1);
        add(f_brr(4, 7, 1'b1),           1'b1, 1'b0, 1'b0);
        add(f_brr(4, 7, 1'b1),           1'b1, 1'b0, 1'b0);
        add(f_brr(4, 7, 1'b1),           1'b0, 1'b1, 1'b0);
        // Flag-to-branch: Z needed, then V not produced, then N needed
        add(f_alu(6, 1, 2, 3'b100),      1'b0, 1'b0, 1'b1);
        add(f_br(0, 1'b1),               1'b1, 1'b0, 1'b0);
        add(f_br(0, 1'b1),               1'b0, 1'b1, 1'b0);
        add(f_alu(6, 1, 2, 3'b100),      1'b0, 1'b0, 1'b0);
        add(f_br(6, 1'b1),               1'b0, 1'b1, 1'b0);
        add(f_alu(6, 1, 2, 3'b100),      1'b0, 1'b0, 1'b0);
        add(f_br(1, 1'b0),               1'b1, 1'b0, 1'b0);
        add(f_br(1, 1'b0),               1'b0, 1'b0, 1'b0);
        add(f_alu(6, 1, 2, 3'b010),      1'b0, 1'b0, 1'b0);
        add(f_br(6, 1'b1),               1'b1, 1'b0, 1'b0);
        add(f_br(6, 1'b1),               1'b0, 1'b1, 1'b0);
        add(f_alu(6, 1, 2, 3'b010),      1'b0, 1'b0, 1'b0);
        add(f_br(0, 1'b1),               1'b0, 1'b1, 1'b0);
        add(f_alu(6, 1, 2, 3'b001),      1'b0, 1'b0, 1'b0);
        add(f_br(3, 1'b1),               1'b1, 1'b0, 1'b0);
        add(f_br(3, 1'b1),               1'b0, 1'b1, 1'b0);
        // Newest writer wins: ALU then LDR to r2, then a user of r2
        add(f_alu(2, 1, 1, 3'b000),      1'b0, 1'b0, 1'b1);
        add(f_ldr(2, 1),                 1'b0, 1'b0, 1'b0);
        add(f_alu(7, 2, 1, 3'b000),      1'b1, 1'b0, 1'b0);
        add(f_alu(7, 2, 1, 3'b000),      1'b0, 1'b0, 1'b0);
        // r0 never tracked
        add(f_ldr(0, 1),                 1'b0, 1'b0, 1'b0);
        add(f_alu(7, 0, 0, 3'b000),      1'b0, 1'b0, 1'b0);
        add(f_brr(0, 7, 1'b1),           1'b0, 1'b1, 1'b0);
        // ALU result needs no stall; invalid ID never stalls
        add(f_alu(8, 1, 1, 3'b000),      1'b0, 1'b0, 1'b0);
        add(f_alu(9, 8, 8, 3'b000),      1'b0, 1'b0, 1'b0);
        add(f_ldr(3, 1),                 1'b0, 1'b0, 1'b0);
        begin
            vec_t v;
            v = f_alu(5, 3, 3, 3'b000);
            v.valid = 1'b0;
            add(v,                       1'b0, 1'b0, 1'b0);
        end

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        push_exp(1'b0, 1'b0);
        @(negedge clk);
        check(900);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            if (tbl[i].do_rst)
                do_reset(500 + i);
            apply(tbl[i], i);
        end

        // Asynchronous reset while r7 is pending a load and a user sits in ID
        apply(f_ldr(7, 1) | '0, 1000);
        drive(f_alu(9, 7, 1, 3'b000));
        push_exp(1'b1, 1'b0);
        @(negedge clk);
        check(1001);
        #1;
        rst = 1'b1;
        #1;
        push_exp(1'b0, 1'b0);
        check(1002);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(1'b0, 1'b0);
        @(negedge clk);
        check(1003);
        @(posedge clk);
        #1;
        drive(f_nop());
        push_exp(1'b0, 1'b0);
        @(negedge clk);
        check(1004);
`ifdef HAZ_PERF_CNT_EN
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_reset: stall_cycles %0d flush_count %0d expected 0 0",
                     stall_cycles, flush_count);
        end
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard unit that replaces direct pipe-register compares with a per-register and per-flag countdown scoreboard.
- Tracks in-flight writers by remaining pipeline distance.
- Detects load-to-use, register-branch-source and flag-to-branch hazards for the instruction in ID.
- Drives PC/IF-ID write enables, an ID/EX bubble and the IF/ID flush.
- Sits beside the ID stage. Pipeline depth and latencies are parameters, so deeper pipelines need no rewrite.

Parameters:
NREG, 16, architectural register count; r0 never tracked
RIDX_W, 4, register index width (clog2(NREG))
WB_DIST, 3, cycles from issue edge until the producer is written in WB (EX, MEM, WB)
FLAG_DIST, 1, cycles from issue edge until flags are committed (end of EX)
BR_RF_THRESH, 1, branchr may read rs from RF when cnt[rs] <= this value (WB write-before-read)
CNT_W, 2, counter width; must hold max(WB_DIST, FLAG_DIST)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  valid instruction in ID
id_rs  in  RIDX_W  source 1
id_rt  in  RIDX_W  source 2
id_rs_used  in  1  rs is read by the instruction
id_rt_used  in  1  rt is read by the instruction
id_rd  in  RIDX_W  destination
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
id_mem_write  in  1  instruction is a store (rt is store data)
id_flag_en  in  3  flags written by the instruction (Z,V,N)
id_branch  in  1  conditional branch, immediate target
id_branchr  in  1  conditional branch, target in rs
id_br_cond  in  3  condition code
id_br_taken  in  1  branch condition evaluated true in ID
pc_wen  out  1  PC write enable
if_id_wen  out  1  IF/ID write enable
id_ex_bubble  out  1  zero the controls entering ID/EX
if_id_flush  out  1  flush IF/ID (taken branch)

Behaviour:
- State:
  - reg_cnt[NREG][CNT_W] and reg_ld[NREG] (producer is a load).
  - flag_cnt[3][CNT_W].
  - On rst: all counters and reg_ld cleared asynchronously.
- issue = id_valid & ~stall. Only issued instructions update the scoreboard.
- Each clock edge:
  - Every nonzero counter decrements by 1.
  - Then, if issue & id_reg_write & id_rd != 0: reg_cnt[id_rd] <= WB_DIST and reg_ld[id_rd] <= id_mem_read. Issue overrides the decrement (newest writer wins).
  - For each f with issue & id_flag_en[f]: flag_cnt[f] <= FLAG_DIST.
- A counter reaching 0 clears reg_ld.
- Hazard terms (combinational, qualified by id_valid; r0 never hazards):
  - l2u: for src in {rs if rs_used, rt if rt_used & ~id_mem_write}: reg_ld[src] & reg_cnt[src] == WB_DIST. Store data is excluded because it is forwarded MEM-to-MEM.
  - brr: id_branchr & reg_cnt[rs] > BR_RF_THRESH.
  - flg: (id_branch | id_branchr) & |(need & flag_pending), where flag_pending[f] = flag_cnt[f] != 0.
- need mask by id_br_cond:
  - 000 {Z}, 001 {Z}, 010 {Z,N}, 011 {N}, 100 {Z,N}, 101 {Z,N}, 110 {V}, 111 {} (unconditional).
- stall = l2u | brr | flg.
- Outputs are combinational and pure functions of state plus ID inputs:
  - pc_wen = ~stall
  - if_id_wen = ~stall
  - id_ex_bubble = stall
  - if_id_flush = id_valid & (id_branch | id_branchr) & id_br_taken & ~stall
- Stall has priority over flush; a stalled branch never flushes.
- Reset values (id_valid=0): pc_wen=1, if_id_wen=1, id_ex_bubble=0, if_id_flush=0.
- Reset mid-stall: the stall drops immediately, because the counters clear asynchronously.
- The scoreboard keeps draining during a stall. A hazard therefore self-resolves in at most WB_DIST cycles, and a deadlock is impossible.
- id_rd == src of the same instruction: the ID instruction's own issue is not a hazard.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[15:0].
  - stall_cycles increments every cycle stall=1.
  - flush_count increments on each if_id_flush.
  - Both saturate at all-ones and clear on rst.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - FLAG_Z=2, FLAG_V=1, FLAG_N=0
  - condition-code localparams
  - function cond_flag_mask(cond) returning the 3-bit need mask
- Sub-module hazard_sb_cnt: one loadable saturating-at-0 down-counter (load, load_val, cnt, busy). It is instantiated NREG-1 times for registers and 3 times for flags.

Test Plan:
- LDR r3 issued, next cycle ADD r5,r3,r1 in ID -> stall=1, pc_wen=0, id_ex_bubble=1 for exactly 1 cycle, then the ADD issues.
- LDR r3 then SW r3 as store data (rt, id_mem_write=1) -> no stall. With r3 as base (rs) instead -> 1-cycle stall.
- ADD r4 then BR (branchr, rs=r4), WB_DIST=3, BR_RF_THRESH=1 -> stall 2 cycles (cnt 3→2→1), issue on the third cycle.
- SUB with flag_en=Z then B cond=000 taken -> 1 stall cycle, then if_id_flush=1 for 1 cycle. Same sequence with cond=110 (V) -> no stall, immediate flush.
- Back-to-back writers to r2 (ALU then LDR), then a user of r2 -> reg_ld reflects the LDR, so the load-use stall occurs. Writes to r0 never stall.
- Assert rst while reg_cnt[r7]=3 with a user of r7 in ID -> stall drops asynchronously. After release all outputs hold their reset values. With HAZ_PERF_CNT_EN, the counters read 0.
